result_uart_tx: RTL and testbench

Reports each classification result over a UART serial line. Watches the `done`/`predicted_digit` pair produced by the top-level inference FSM and, on each rising edge of `done`, transmits the 5-byte ASCII message "D:<digit>\r\n" to a host terminal. It sits beside the top-level FSM and the 7-segment display as a second consumer of the result interface.

---
 rtl/result_uart_tx_pkg.sv | 34 +++
 rtl/result_uart_tx_byte.sv | 71 +++++++
 rtl/result_uart_tx.sv | 119 +++++++++++
 tb/tb_result_uart_tx.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/result_uart_tx_pkg.sv
// Shared constants for the result reporting UART: ASCII codes, serializer states
// and the message byte table.
package result_uart_tx_pkg;

  localparam logic [7:0] ASC_D     = 8'h44;
  localparam logic [7:0] ASC_COLON = 8'h3A;
  localparam logic [7:0] ASC_CR    = 8'h0D;
  localparam logic [7:0] ASC_LF    = 8'h0A;
  localparam logic [7:0] ASC_ZERO  = 8'h30;
  localparam logic [7:0] ASC_QMARK = 8'h3F;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } uart_state_e;

  function automatic logic [7:0] digit_ascii(input logic [3:0] digit);
    return (digit <= 4'd9) ? (ASC_ZERO + {4'h0, digit}) : ASC_QMARK;
  endfunction

  // Message layout "D:<digit>\r\n"; indices past the end read as line-feed filler.
  function automatic logic [7:0] msg_byte(input logic [2:0] idx, input logic [3:0] digit);
    case (idx)
      3'd0:    return ASC_D;
      3'd1:    return ASC_COLON;
      3'd2:    return digit_ascii(digit);
      3'd3:    return ASC_CR;
      default: return ASC_LF;
    endcase
  endfunction

endpackage

// File: rtl/result_uart_tx_byte.sv
// Single-byte 8N1 serializer. tx_ready is high while idle and in the last cycle
// of a stop bit, so a byte offered then starts with no idle gap.
module result_uart_tx_byte
  import result_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       txd
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  uart_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             baud_last;

  assign baud_last = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (tx_valid) state_d = S_START;
      S_START: if (baud_last) state_d = S_DATA;
      S_DATA:  if (baud_last && bit_idx_q == 3'd7) state_d = S_STOP;
      S_STOP:  if (baud_last) state_d = tx_valid ? S_START : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d     = (state_q == S_IDLE || baud_last) ? '0 : cnt_q + CNT_W'(1);
    bit_idx_d = bit_idx_q;
    if (state_q == S_START)
      bit_idx_d = 3'd0;
    else if (state_q == S_DATA && baud_last)
      bit_idx_d = bit_idx_q + 3'd1;
    shift_d = (tx_valid && tx_ready) ? tx_data : shift_q;
  end

  always_comb begin
    tx_ready = (state_q == S_IDLE) || (state_q == S_STOP && baud_last);
    case (state_q)
      S_START: txd = 1'b0;
      S_DATA:  txd = shift_q[bit_idx_q];
      default: txd = 1'b1;
    endcase
  end

endmodule

// File: rtl/result_uart_tx.sv
// Sends "D:<digit>\r\n" over UART on each rising edge of done, with a one-deep
// pending buffer for results that arrive while a message is in flight.
module result_uart_tx
  import result_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int MSG_LEN      = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       done,
  input  logic [3:0] predicted_digit,
  output logic       uart_txd,
  output logic       busy,
  output logic       msg_sent,
  output logic       overrun
);

  localparam logic [2:0] LAST_IDX = 3'(MSG_LEN - 1);

  logic       done_prev_q, busy_q, busy_d, msg_sent_q, msg_sent_d;
  logic       overrun_q, overrun_d, pend_q, pend_d;
  logic [2:0] byte_idx_q, byte_idx_d;
  logic [3:0] cur_digit_q, cur_digit_d, pend_digit_q, pend_digit_d;
  logic       trig, start, tx_valid, tx_ready;
  logic [3:0] start_digit;
  logic [7:0] tx_data;

  assign trig = done & ~done_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_prev_q  <= 1'b0;
      busy_q       <= 1'b0;
      msg_sent_q   <= 1'b0;
      overrun_q    <= 1'b0;
      pend_q       <= 1'b0;
      byte_idx_q   <= 3'd0;
      cur_digit_q  <= 4'd0;
      pend_digit_q <= 4'd0;
    end else begin
      done_prev_q  <= done;
      busy_q       <= busy_d;
      msg_sent_q   <= msg_sent_d;
      overrun_q    <= overrun_d;
      pend_q       <= pend_d;
      byte_idx_q   <= byte_idx_d;
      cur_digit_q  <= cur_digit_d;
      pend_digit_q <= pend_digit_d;
    end
  end

  always_comb begin
    busy_d       = busy_q;
    msg_sent_d   = 1'b0;
    overrun_d    = overrun_q;
    pend_d       = pend_q;
    byte_idx_d   = byte_idx_q;
    cur_digit_d  = cur_digit_q;
    pend_digit_d = pend_digit_q;
    start        = 1'b0;
    start_digit  = cur_digit_q;
    tx_valid     = 1'b0;

    if (!busy_q) begin
      // A waiting result goes first; a fresh edge in the same cycle takes its buffer slot.
      if (pend_q) begin
        start       = 1'b1;
        start_digit = pend_digit_q;
        pend_d      = trig;
        if (trig) pend_digit_d = predicted_digit;
      end else if (trig) begin
        start       = 1'b1;
        start_digit = predicted_digit;
      end
    end else begin
      if (trig) begin
        if (pend_q) overrun_d = 1'b1;
        pend_d       = 1'b1;
        pend_digit_d = predicted_digit;
      end
      if (tx_ready) begin
        if (byte_idx_q == LAST_IDX) begin
          busy_d     = 1'b0;
          msg_sent_d = 1'b1;
        end else begin
          tx_valid   = 1'b1;
          byte_idx_d = byte_idx_q + 3'd1;
        end
      end
    end

    if (start) begin
      tx_valid    = 1'b1;
      busy_d      = 1'b1;
      byte_idx_d  = 3'd0;
      cur_digit_d = start_digit;
    end
  end

  assign tx_data = start ? msg_byte(3'd0, start_digit)
                         : msg_byte(byte_idx_q + 3'd1, cur_digit_q);

  result_uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .txd      (uart_txd)
  );

  assign busy     = busy_q;
  assign msg_sent = msg_sent_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_result_uart_tx.sv
// Bench for result_uart_tx: a UART line decoder checks every received byte
// against a queue of expected digits pushed when each done edge is driven.
module tb_result_uart_tx;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       done = 1'b0;
  logic [3:0] predicted_digit = 4'd0;
  logic       uart_txd, busy, msg_sent, overrun;

  always #5 clk = ~clk;

  result_uart_tx #(.CLKS_PER_BIT(CPB), .MSG_LEN(5)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .done            (done),
    .predicted_digit (predicted_digit),
    .uart_txd        (uart_txd),
    .busy            (busy),
    .msg_sent        (msg_sent),
    .overrun         (overrun)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_byte(input int idx, input int d);
    case (idx)
      0: return 8'h44;
      1: return 8'h3A;
      2: return (d < 10) ? 8'(8'h30 + d) : 8'h3F;
      3: return 8'h0D;
      default: return 8'h0A;
    endcase
  endfunction

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Line decoder, sampled mid-bit on the falling edge.
  int         exp_q[$];
  int         cur_exp = -1;
  int         rx_idx = 0, rx_cnt = 0, rx_bytes = 0, msg_cnt = 0, t0 = 0;
  logic       rx_active = 1'b0;
  logic [7:0] rx_sh = 8'h00;

  always @(negedge clk) begin
    if (!rst_n) begin
      rx_active = 1'b0;
      rx_idx    = 0;
    end else if (!rx_active) begin
      if (uart_txd === 1'b0) begin
        rx_active = 1'b1;
        rx_cnt    = 0;
        if (rx_idx == 0) begin
          t0 = cyc;
          check("msg_expected", 32'(exp_q.size() != 0), 1);
          cur_exp = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
        end
      end
    end else begin
      rx_cnt++;
      if (rx_cnt == CPB / 2)
        check("start_bit", 32'(uart_txd), 0);
      else if (rx_cnt > CPB && rx_cnt < 9 * CPB && (rx_cnt % CPB) == CPB / 2)
        rx_sh[rx_cnt / CPB - 1] = uart_txd;
      else if (rx_cnt == 9 * CPB + CPB / 2) begin
        check("stop_bit", 32'(uart_txd), 1);
        rx_bytes++;
        if (cur_exp >= 0)
          check($sformatf("byte%0d_digit%0d", rx_idx, cur_exp), 32'(rx_sh),
                32'(model_byte(rx_idx, cur_exp)));
        rx_idx    = (rx_idx == 4) ? 0 : rx_idx + 1;
        rx_active = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && msg_sent === 1'b1) begin
      msg_cnt++;
      check("msg_sent_time", 32'(cyc - t0), 32'(50 * CPB));
      check("msg_sent_rxidx", 32'(rx_idx), 0);
    end
  end

  int low_run = 0, last_low = 0;
  always @(negedge clk) begin
    if (!rst_n) low_run = 0;
    else if (busy === 1'b0) low_run++;
    else begin
      if (low_run > 0) last_low = low_run;
      low_run = 0;
    end
  end

  task automatic raise(input int d);
    @(negedge clk);
    predicted_digit = 4'(d);
    done = 1'b1;
  endtask

  task automatic drop();
    @(negedge clk);
    done = 1'b0;
  endtask

  task automatic wait_msgs(input int target, input int budget);
    int n = 0;
    while (msg_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("msg_wait", 32'(msg_cnt), 32'(target));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int b, m;
    // Reset and quiet line
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_txd", 32'(uart_txd), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_msg_sent", 32'(msg_sent), 0);
    check("rst_overrun", 32'(overrun), 0);
    repeat (100) @(negedge clk);
    check("idle_bytes", 32'(rx_bytes), 0);
    check("idle_txd", 32'(uart_txd), 1);
    check("idle_busy", 32'(busy), 0);

    // Single result, done held high well past the message
    exp_q.push_back(7);
    raise(7);
    @(negedge clk);
    check("busy_rise", 32'(busy), 1);
    wait_msgs(1, 400);
    repeat (300) @(negedge clk);
    check("held_done_msgs", 32'(msg_cnt), 1);
    check("held_done_bytes", 32'(rx_bytes), 5);
    drop();

    // Out-of-range digit
    exp_q.push_back(12);
    raise(12);
    wait_msgs(2, 400);
    drop();
    repeat (5) @(negedge clk);

    // Back-to-back via the pending buffer
    exp_q.push_back(3);
    raise(3);
    repeat (29) @(negedge clk);
    done = 1'b0;
    repeat (30) @(negedge clk);
    predicted_digit = 4'd5;
    done = 1'b1;
    exp_q.push_back(5);
    wait_msgs(4, 600);
    check("b2b_busy_gap", 32'(last_low), 1);
    check("b2b_overrun", 32'(overrun), 0);
    drop();
    repeat (5) @(negedge clk);

    // Overrun: 2 is replaced by 4 before it is sent
    exp_q.push_back(1);
    raise(1);
    repeat (40) @(negedge clk);
    done = 1'b0;
    repeat (20) @(negedge clk);
    predicted_digit = 4'd2;
    done = 1'b1;
    exp_q.push_back(2);
    repeat (40) @(negedge clk);
    done = 1'b0;
    @(negedge clk);
    check("pre_overrun", 32'(overrun), 0);
    repeat (19) @(negedge clk);
    predicted_digit = 4'd4;
    done = 1'b1;
    exp_q[exp_q.size() - 1] = 4;
    @(negedge clk);
    check("overrun_set", 32'(overrun), 1);
    wait_msgs(6, 800);
    drop();
    repeat (50) @(negedge clk);
    check("overrun_sticky", 32'(overrun), 1);

    // Reset during byte 2, data bit 3
    exp_q.push_back(9);
    raise(9);
    repeat (98) @(negedge clk);
    check("mid_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("abort_txd", 32'(uart_txd), 1);
    check("abort_busy", 32'(busy), 0);
    check("abort_overrun", 32'(overrun), 0);
    check("abort_msg_sent", 32'(msg_sent), 0);
    exp_q.delete();
    done = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    b = rx_bytes;
    m = msg_cnt;
    repeat (300) @(negedge clk);
    check("no_resume_bytes", 32'(rx_bytes), 32'(b));
    check("no_resume_busy", 32'(busy), 0);

    exp_q.push_back(0);
    raise(0);
    wait_msgs(m + 1, 400);
    drop();
    repeat (5) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
